// File: rtl/bht_port_scheduler_pkg.sv
// Shared types and constants for the branch-history-table port scheduler.
package bht_port_scheduler_pkg;

    // Width of the saturating statistics counters
    localparam int CNT_W = 32;

    // Scheduler operating mode: table clearing after reset, then normal service
    typedef enum logic {
        INIT,
        RUN
    } state_t;

    // What the single table port is doing this cycle
    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } port_op_t;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/bht_port_scheduler_upd_fifo.sv
// Update queue: small FIFO whose live entries are exposed oldest-first so the
// scheduler can forward pending outcomes to lookups.
module upd_fifo
    import bht_port_scheduler_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 5,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic [CW-1:0]                count,
    output logic [DEPTH-1:0][WIDTH-1:0]  entries,
    output logic [DEPTH-1:0]             occupied
);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [PW-1:0]               wr_ptr;
    logic [PW-1:0]               rd_ptr;

    // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    // Present entries in age order (index 0 = oldest) with a live flag per slot
    always_comb begin
        head = mem[rd_ptr];
        for (int k = 0; k < DEPTH; k++) begin
            entries[k]  = mem[rd_ptr + PW'(k)];
            occupied[k] = (CW'(k) < count);
        end
    end

endmodule

// File: rtl/bht_port_scheduler.sv
// Branch history table port scheduler: shares one single-port table between
// prediction lookups and queued updates, with forwarding and starvation control.
module bht_port_scheduler
    import bht_port_scheduler_pkg::*;
#(
    parameter int IDX_W  = 4,
    parameter int QDEPTH = 4,
    parameter int STARVE = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pred_req,
    input  logic [IDX_W-1:0]  pred_idx,
    output logic              pred_gnt,
    output logic              pred_valid,
    output logic              pred_taken,
    input  logic              upd_req,
    input  logic [IDX_W-1:0]  upd_idx,
    input  logic              upd_taken,
    input  logic              upd_pred,
    output logic              upd_ready,
    output logic              tbl_en,
    output logic              tbl_we,
    output logic [IDX_W-1:0]  tbl_addr,
    output logic              tbl_wdata,
    input  logic              tbl_rdata,
    output logic [CNT_W-1:0]  miss_count,
    output logic [CNT_W-1:0]  upd_count
);

    localparam int EW  = IDX_W + 1;
    localparam int QPW = $clog2(QDEPTH);
    localparam int QCW = QPW + 1;
    localparam int SW  = $clog2(STARVE + 1);
    localparam logic [QCW-1:0] FULL_CNT   = QCW'(QDEPTH);
    localparam logic [SW-1:0]  STARVE_MAX = SW'(STARVE);

    state_t                       state;
    state_t                       state_nxt;
    port_op_t                     op;
    logic [IDX_W-1:0]             init_addr;
    logic [SW-1:0]                starve;
    logic [EW-1:0]                head;
    logic [QCW-1:0]               count;
    logic [QDEPTH-1:0][EW-1:0]    entries;
    logic [QDEPTH-1:0]            occupied;
    logic                         enq;
    logic                         deq;
    logic                         fwd_hit;
    logic                         fwd_val;
    logic                         fwd_hit_q;
    logic                         fwd_val_q;

    upd_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (enq),
        .push_data ({upd_idx, upd_taken}),
        .pop       (deq),
        .head      (head),
        .count     (count),
        .entries   (entries),
        .occupied  (occupied)
    );

    // Mode register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= INIT;
        else       state <= state_nxt;
    end

    // Leave INIT once the last table entry has been cleared
    always_comb begin
        state_nxt = state;
        if (state == INIT && init_addr == '1) state_nxt = RUN;
    end

    // Walk the table address while clearing
    always_ff @(posedge clk or posedge reset) begin
        if (reset)              init_addr <= '0;
        else if (state == INIT) init_addr <= init_addr + IDX_W'(1);
    end

    // Port arbitration: a full queue or a starved queue beats lookups, lookups beat idle drains
    always_comb begin
        op = IDLE;
        if (!reset && state == RUN) begin
            if (count == FULL_CNT)                        op = DRAIN;
            else if (starve == STARVE_MAX && count != '0) op = DRAIN;
            else if (pred_req)                            op = READ;
            else if (count != '0)                         op = DRAIN;
        end
    end

    // Drive the table port and handshakes from the chosen operation
    always_comb begin
        tbl_en    = 1'b0;
        tbl_we    = 1'b0;
        tbl_addr  = '0;
        tbl_wdata = 1'b0;
        pred_gnt  = 1'b0;
        deq       = 1'b0;
        upd_ready = !reset && state == RUN && count != FULL_CNT;
        if (!reset && state == INIT) begin
            tbl_en   = 1'b1;
            tbl_we   = 1'b1;
            tbl_addr = init_addr;
        end else begin
            case (op)
                READ: begin
                    pred_gnt = 1'b1;
                    tbl_en   = 1'b1;
                    tbl_addr = pred_idx;
                end
                DRAIN: begin
                    tbl_en    = 1'b1;
                    tbl_we    = 1'b1;
                    tbl_addr  = head[EW-1:1];
                    tbl_wdata = head[0];
                    deq       = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign enq = upd_req & upd_ready;

    // Find the youngest pending outcome for the lookup index; a same-cycle enqueue is youngest of all
    always_comb begin
        fwd_hit = 1'b0;
        fwd_val = 1'b0;
        for (int k = 0; k < QDEPTH; k++) begin
            if (occupied[k] && entries[k][EW-1:1] == pred_idx) begin
                fwd_hit = 1'b1;
                fwd_val = entries[k][0];
            end
        end
        if (enq && upd_idx == pred_idx) begin
            fwd_hit = 1'b1;
            fwd_val = upd_taken;
        end
    end

    // Capture the lookup result source alongside the grant
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pred_valid <= 1'b0;
            fwd_hit_q  <= 1'b0;
            fwd_val_q  <= 1'b0;
        end else begin
            pred_valid <= pred_gnt;
            if (pred_gnt) begin
                fwd_hit_q <= fwd_hit;
                fwd_val_q <= fwd_val;
            end
        end
    end

    assign pred_taken = pred_valid & (fwd_hit_q ? fwd_val_q : tbl_rdata);

    // Count lookups that bypass a waiting queue; any drain or an empty queue resets the run
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve <= '0;
        end else if (deq || count == '0) begin
            starve <= '0;
        end else if (pred_gnt && starve != STARVE_MAX) begin
            starve <= starve + SW'(1);
        end
    end

    // Saturating statistics on every accepted update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            upd_count  <= '0;
            miss_count <= '0;
        end else if (enq) begin
            upd_count <= sat_inc(upd_count);
            if (upd_taken != upd_pred) miss_count <= sat_inc(miss_count);
        end
    end

endmodule

// File: doc/bht_port_scheduler.md
BHT_PORT_SCHEDULER -- requirements
Module: bht_port_scheduler

Interface
REQ-001 The block SHALL have parameter IDX_W, default 4, the table index width (2^IDX_W one-bit entries).
REQ-002 The block SHALL have parameter QDEPTH, default 4, the update-queue depth (power of two, >=2).
REQ-003 The block SHALL have parameter STARVE, default 8, the maximum consecutive prediction grants while the queue is non-empty.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 pred_req  in  1  lookup request.
REQ-007 pred_idx  in  IDX_W  lookup index.
REQ-008 pred_gnt  out  1  combinational grant of pred_req this cycle.
REQ-009 pred_valid  out  1  registered; high exactly one cycle after a grant.
REQ-010 pred_taken  out  1  prediction, valid with pred_valid.
REQ-011 upd_req  in  1  resolved-branch update request.
REQ-012 upd_idx  in  IDX_W  update index.
REQ-013 upd_taken  in  1  actual outcome.
REQ-014 upd_pred  in  1  prediction that was used for this branch.
REQ-015 upd_ready  out  1  queue can accept; enqueue occurs when upd_req & upd_ready.
REQ-016 tbl_en, tbl_we  out  1 each  single-port table strobe and write enable.
REQ-017 tbl_addr  out  IDX_W, tbl_wdata  out  1, tbl_rdata  in  1  table address/data; read data returns one cycle after tbl_en & !tbl_we.
REQ-018 miss_count  out  32  saturating count of accepted updates with upd_taken != upd_pred.
REQ-019 upd_count  out  32  saturating count of accepted updates.

Function
REQ-020 FSM states SHALL be INIT and RUN; reset enters INIT.
REQ-021 INIT SHALL write 0 to entries 0..2^IDX_W-1, one per cycle ascending, then enter RUN (2^IDX_W cycles); pred_gnt and upd_ready SHALL be 0 in INIT.
REQ-022 In RUN, upd_ready SHALL equal (queue count < QDEPTH).
REQ-023 Table port per RUN cycle, priority: drain if count==QDEPTH; else drain if starve counter==STARVE and count>0; else read if pred_req; else drain if count>0; else idle.
REQ-024 Drain SHALL write oldest entry (tbl_we=1, tbl_addr=idx, tbl_wdata=taken) and pop it.
REQ-025 Read SHALL assert pred_gnt, tbl_en=1, tbl_we=0, tbl_addr=pred_idx.
REQ-026 Starve counter SHALL increment on each grant with count>0, clear on any drain or when count==0, saturate at STARVE.
REQ-027 Forwarding: on grant, if pred_idx matches any queued entry or the same-cycle enqueue, pred_taken SHALL be the youngest match's taken bit (registered); otherwise tbl_rdata.
REQ-028 Same-cycle enqueue and drain SHALL leave count unchanged; FIFO order preserved across pointer wrap.
REQ-029 Counters SHALL update on the enqueue cycle, visible next cycle, and hold at 32'hFFFFFFFF.

Reset
REQ-030 reset SHALL asynchronously clear queue, pointers, count, starve counter, counters, pred_valid, pred_taken, and force INIT with init address 0; asserted mid-operation it SHALL discard queued updates and restart INIT.
REQ-031 During reset, pred_gnt, upd_ready, tbl_en, tbl_we SHALL be 0.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, port-operation enum (IDLE/READ/DRAIN), and the 32-bit counter width constant.
REQ-033 The queue SHALL be a sub-module upd_fifo (parameterised depth/width, exposing all entries for forwarding).

Verification
REQ-034 Reset release, IDX_W=4 -> 16 INIT writes idx 0..15 data 0, then upd_ready=1; lookup idx 5 -> pred_taken=0.
REQ-035 Enqueue (idx 3, taken 1, pred 0) then immediate lookup idx 3 -> pred_taken=1 via forwarding; miss_count=1, upd_count=1.
REQ-036 Continuous pred_req with 1 queued update -> exactly one drain after 8 consecutive grants; pred_gnt low that cycle.
REQ-037 Fill 4 updates under continuous pred_req -> upd_ready=0, next cycle drains, pred_gnt=0; 6 mixed enqueue/drain cycles preserve write order across wrap.
REQ-038 Two queued updates to idx 7 (taken 1 then 0), lookup 7 -> pred_taken=0 (youngest wins).
REQ-039 Assert reset with 3 queued entries -> queue empty, counters 0, INIT restarts at addr 0; no queued write reaches table.
